// File: rtl/seq_tx_1100.sv
// -----------------------------------------------------------------------------
// seq_tx_1100
//
// Serial frame transmitter. A payload word is accepted over a valid/ready
// handshake and sent one bit per clock on q as:
//   sync pattern 1100, payload MSB-first with bit stuffing, 2 flush slots.
// Whenever the last three bits emitted in DATA/FLUSH are 1,1,0 the next bit is
// a forced 1. As a result, 1100 appears on the line only at a frame start.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   tx_data   payload word, sampled on the accept edge
//   tx_valid  payload word available
//   tx_ready  block can accept a word (IDLE and out of reset)
//   q         serial line, registered
//   busy      a frame (SYNC/DATA/FLUSH) is being driven on q
//   sync_flag current q bit is a sync bit
//   stuffed   current q bit is a stuffed bit
// -----------------------------------------------------------------------------
module seq_tx_1100 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         q,
  output logic         busy,
  output logic         sync_flag,
  output logic         stuffed
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  // The state names the phase of the bit currently shown on q.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_DATA  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_idx_q, sync_idx_d;   // index of the sync bit on q
  logic [W-1:0]   shreg_q, shreg_d;         // remaining payload, MSB next
  logic [CW-1:0]  left_q, left_d;           // payload bits still to send
  logic           flush_idx_q, flush_idx_d; // flush slot on q (0 or 1)
  logic [2:0]     hist_q, hist_d;           // last 3 DATA/FLUSH bits, newest in [0]
  logic           line_q, line_d;
  logic           busy_q, busy_d;
  logic           sync_q, sync_d;
  logic           stuff_q, stuff_d;

  logic           force_one;

  // Last three emitted bits were 1,1,0: another 0 would complete 1100.
  assign force_one = (hist_q == 3'b110);

  always_comb begin
    state_d     = state_q;
    sync_idx_d  = sync_idx_q;
    shreg_d     = shreg_q;
    left_d      = left_q;
    flush_idx_d = flush_idx_q;
    hist_d      = hist_q;
    line_d      = 1'b0;
    busy_d      = 1'b0;
    sync_d      = 1'b0;
    stuff_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        hist_d = 3'b000;
        if (tx_valid) begin
          state_d    = S_SYNC;
          shreg_d    = tx_data;
          sync_idx_d = 2'd0;
          line_d     = 1'b1;
          busy_d     = 1'b1;
          sync_d     = 1'b1;
        end
      end

      S_SYNC: begin
        busy_d = 1'b1;
        if (sync_idx_q != 2'd3) begin
          sync_idx_d = sync_idx_q + 2'd1;
          // Pattern 1,1,0,0: only the bit after index 0 is still a 1.
          line_d     = (sync_idx_q == 2'd0);
          sync_d     = 1'b1;
        end else begin
          // First payload bit; history starts empty so it is never stuffed.
          state_d = S_DATA;
          line_d  = shreg_q[W-1];
          shreg_d = {shreg_q[W-2:0], 1'b0};
          left_d  = CW'(W - 1);
          hist_d  = {2'b00, shreg_q[W-1]};
        end
      end

      S_DATA: begin
        busy_d = 1'b1;
        if (left_q == '0) begin
          // Payload exhausted: first flush slot, forced to 1 if needed.
          state_d     = S_FLUSH;
          flush_idx_d = 1'b0;
          line_d      = force_one;
          stuff_d     = force_one;
        end else if (force_one) begin
          // Stuffed bit: payload is not consumed.
          line_d  = 1'b1;
          stuff_d = 1'b1;
        end else begin
          line_d  = shreg_q[W-1];
          shreg_d = {shreg_q[W-2:0], 1'b0};
          left_d  = left_q - CW'(1);
        end
        hist_d = {hist_q[1:0], line_d};
      end

      S_FLUSH: begin
        if (!flush_idx_q) begin
          busy_d      = 1'b1;
          flush_idx_d = 1'b1;
          line_d      = force_one;
          stuff_d     = force_one;
          hist_d      = {hist_q[1:0], line_d};
        end else begin
          state_d = S_IDLE;
          hist_d  = 3'b000;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync_idx_q  <= 2'd0;
      shreg_q     <= '0;
      left_q      <= '0;
      flush_idx_q <= 1'b0;
      hist_q      <= 3'b000;
      line_q      <= 1'b0;
      busy_q      <= 1'b0;
      sync_q      <= 1'b0;
      stuff_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_idx_q  <= sync_idx_d;
      shreg_q     <= shreg_d;
      left_q      <= left_d;
      flush_idx_q <= flush_idx_d;
      hist_q      <= hist_d;
      line_q      <= line_d;
      busy_q      <= busy_d;
      sync_q      <= sync_d;
      stuff_q     <= stuff_d;
    end
  end

  // Gated by rst so the block never advertises readiness while held in reset.
  assign tx_ready  = (state_q == S_IDLE) && rst;
  assign q         = line_q;
  assign busy      = busy_q;
  assign sync_flag = sync_q;
  assign stuffed   = stuff_q;

endmodule
